// File: rtl/soc_pkg.sv
// Shared SoC definitions: arbiter port identities and block RAM geometry.
package soc_pkg;

    typedef enum logic {
        ARB_CPU    = 1'b0,
        ARB_LOADER = 1'b1
    } arb_port_t;

    localparam int RAM_WORDS      = 16384;
    localparam int RAM_ADDR_WIDTH = 14;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester arbiter. With ARBITER_ROUND_ROBIN_EN defined the favoured
// port alternates after every contested grant (port 0 favoured out of reset);
// otherwise port 1 (loader) always wins a contest.
module rr_arbiter2
    import soc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    arb_port_t favour;
    logic      contested;

    // Uncontested requests pass straight through; a contest goes to the favourite
    always_comb begin
        contested = req[0] & req[1];
        grant     = req;
        if (contested) begin
            grant = (favour == ARB_LOADER) ? 2'b10 : 2'b01;
        end
    end

`ifdef ARBITER_ROUND_ROBIN_EN
    // Hand the favour to the losing port after each contested grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            favour <= ARB_CPU;
        end else if (contested) begin
            favour <= (favour == ARB_CPU) ? ARB_LOADER : ARB_CPU;
        end
    end
`else
    // Fixed priority: the loader is permanently the favourite
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            favour <= ARB_LOADER;
        end else begin
            favour <= ARB_LOADER;
        end
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port block RAM between the CPU bus (port 0) and the
// loader/DMA master (port 1). One access per cycle, read data returned two
// cycles after the strobe. Arbitration policy selected by ARBITER_ROUND_ROBIN_EN.
module ram_arbiter
    import soc_pkg::*;
#(
    parameter  int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter  int DATA_WIDTH = 32,
    localparam int MASK_W     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [MASK_W-1:0]     m0_wmask,
    input  logic                  m0_rstrb,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_rbusy,
    output logic                  m0_wbusy,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [MASK_W-1:0]     m1_wmask,
    input  logic                  m1_rstrb,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_rbusy,
    output logic                  m1_wbusy,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [MASK_W-1:0]     ram_wmask,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    logic [1:0]            rstrb, rpend, rreq, wreq, req;
    logic [1:0]            grant, wgrant, rgrant;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic                  rd_valid;
    arb_port_t             rd_port;

    // A write outranks a read on the same port; the read then stays pending
    always_comb begin
        rstrb  = {m1_rstrb, m0_rstrb};
        wreq   = {|m1_wmask, |m0_wmask};
        rreq   = rstrb | rpend;
        req    = rreq | wreq;
        wgrant = grant & wreq;
        rgrant = grant & ~wreq;
    end

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .grant (grant)
    );

    // Granted port drives the RAM; idle cycles keep the last address and never write
    always_comb begin
        ram_addr  = last_addr;
        ram_wdata = '0;
        ram_wmask = '0;
        if (grant[1]) begin
            ram_addr  = m1_addr;
            ram_wdata = m1_wdata;
            if (wreq[1]) ram_wmask = m1_wmask;
        end else if (grant[0]) begin
            ram_addr  = m0_addr;
            ram_wdata = m0_wdata;
            if (wreq[0]) ram_wmask = m0_wmask;
        end
    end

    // Pending reads, read-pipeline tag and held address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpend     <= '0;
            rd_valid  <= 1'b0;
            rd_port   <= ARB_CPU;
            last_addr <= '0;
        end else begin
            rpend    <= rreq & ~rgrant;
            rd_valid <= |rgrant;
            if (|rgrant) rd_port <= rgrant[1] ? ARB_LOADER : ARB_CPU;
            if (|grant) last_addr <= ram_addr;
        end
    end

    // Capture RAM output into the requesting port's read register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else if (rd_valid) begin
            if (rd_port == ARB_LOADER) m1_rdata <= ram_rdata;
            else                       m0_rdata <= ram_rdata;
        end
    end

    // Busy handshakes follow the live requests plus the in-flight read
    always_comb begin
        m0_rbusy = rstrb[0] | rpend[0] | (rd_valid & (rd_port == ARB_CPU));
        m1_rbusy = rstrb[1] | rpend[1] | (rd_valid & (rd_port == ARB_LOADER));
        m0_wbusy = wreq[0] & ~wgrant[0];
        m1_wbusy = wreq[1] & ~wgrant[1];
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural registered-read RAM.
// Expectations for arbitration order depend on ARBITER_ROUND_ROBIN_EN.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] m0_addr, m1_addr, ram_addr;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, ram_wdata, ram_rdata;
    logic [3:0]  m0_wmask, m1_wmask, ram_wmask;
    logic        m0_rstrb, m1_rstrb, m0_rbusy, m1_rbusy, m0_wbusy, m1_wbusy;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] mem [0:16383];

    ram_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
        .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy), .m0_wbusy(m0_wbusy),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
        .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy), .m1_wbusy(m1_wbusy),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM: byte-masked write, registered read
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_wmask[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a read completes when rbusy falls; compare against the queued value
    logic        prev0 = 1'b0, prev1 = 1'b0;
    logic [31:0] mon_exp;
    always @(negedge clk) begin
        if (reset) begin
            prev0 = 1'b0;
            prev1 = 1'b0;
        end else begin
            if (prev0 && !m0_rbusy) begin
                if (q0.size() == 0) check("m0_rdata_unexpected", m0_rdata, 32'hx);
                else begin
                    mon_exp = q0.pop_front();
                    check("m0_rdata", m0_rdata, mon_exp);
                end
            end
            if (prev1 && !m1_rbusy) begin
                if (q1.size() == 0) check("m1_rdata_unexpected", m1_rdata, 32'hx);
                else begin
                    mon_exp = q1.pop_front();
                    check("m1_rdata", m1_rdata, mon_exp);
                end
            end
            prev0 = m0_rbusy;
            prev1 = m1_rbusy;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int port, input logic [13:0] a, input logic [31:0] d, input logic [3:0] m);
        int n;
        n = 0;
        if (port == 0) begin m0_addr = a; m0_wdata = d; m0_wmask = m; end
        else           begin m1_addr = a; m1_wdata = d; m1_wmask = m; end
        @(negedge clk);
        while (((port == 0) ? m0_wbusy : m1_wbusy) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("wr_timeout", n, 0);
        step();
        m0_wmask = 4'h0;
        m1_wmask = 4'h0;
    endtask

    task automatic rd(input int port, input logic [13:0] a, input logic [31:0] e);
        if (port == 0) begin m0_addr = a; m0_rstrb = 1'b1; q0.push_back(e); end
        else           begin m1_addr = a; m1_rstrb = 1'b1; q1.push_back(e); end
        step();
        m0_rstrb = 1'b0;
        m1_rstrb = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    int c0, c1, starve, acc, m1_cnt;
    logic m0_done;

    initial begin
        reset = 1'b1;
        m0_addr = '0; m0_wdata = '0; m0_wmask = '0; m0_rstrb = 1'b0;
        m1_addr = '0; m1_wdata = '0; m1_wmask = '0; m1_rstrb = 1'b0;
        @(negedge clk);
        check("rst_m0_rdata", m0_rdata, 0);
        check("rst_m1_rdata", m1_rdata, 0);
        check("rst_ram_wmask", {28'd0, ram_wmask}, 0);
        check("rst_ram_addr", {18'd0, ram_addr}, 0);
        check("rst_m0_rbusy", {31'd0, m0_rbusy}, 0);
        check("rst_m1_wbusy", {31'd0, m1_wbusy}, 0);
        m0_rstrb = 1'b1;
        #1;
        check("rst_rbusy_follows_rstrb", {31'd0, m0_rbusy}, 1);
        m0_rstrb = 1'b0;
        step();
        reset = 1'b0;
        step();

        // Preload through the loader port
        wr(1, 14'h0010, 32'hCAFEF00D, 4'hF);
        wr(1, 14'h0003, 32'h00000011, 4'hF);
        wr(1, 14'h0004, 32'h00000022, 4'hF);
        wr(1, 14'h0007, 32'h12345678, 4'hF);

        // Reset arriving while a read is in flight
        m0_addr = 14'h0010;
        m0_rstrb = 1'b1;
        step();
        m0_rstrb = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        check("midrst_rbusy", {31'd0, m0_rbusy}, 0);
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_rdata", m0_rdata, 0);
        check("midrst_rbusy_after", {31'd0, m0_rbusy}, 0);
        repeat (3) step();
        check("midrst_no_stale", m0_rdata, 0);

        // Uncontested write then read
        m1_addr = 14'h0005; m1_wdata = 32'hDEADBEEF; m1_wmask = 4'hF;
        @(negedge clk);
        check("wr_m1_wbusy", {31'd0, m1_wbusy}, 0);
        check("wr_ram_wmask", {28'd0, ram_wmask}, 32'hF);
        check("wr_ram_addr", {18'd0, ram_addr}, 32'h5);
        step();
        m1_wmask = 4'h0;
        m0_addr = 14'h0005; m0_rstrb = 1'b1; q0.push_back(32'hDEADBEEF);
        c0 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m0_rbusy) c0++;
            step();
            m0_rstrb = 1'b0;
        end
        check("rd_rbusy_cycles", c0, 2);

        // Simultaneous reads
        m0_addr = 14'h0003; m1_addr = 14'h0004;
        m0_rstrb = 1'b1; m1_rstrb = 1'b1;
        q0.push_back(32'h11); q1.push_back(32'h22);
        c0 = 0; c1 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m0_rbusy) c0++;
            if (m1_rbusy) c1++;
            step();
            m0_rstrb = 1'b0; m1_rstrb = 1'b0;
        end
`ifdef ARBITER_ROUND_ROBIN_EN
        check("rr_m0_rbusy_cycles", c0, 2);
        check("rr_m1_rbusy_cycles", c1, 3);
`else
        check("fp_m0_rbusy_cycles", c0, 3);
        check("fp_m1_rbusy_cycles", c1, 2);
`endif

        // Byte-lane write
        m0_addr = 14'h0007; m0_wdata = 32'h00AB0000; m0_wmask = 4'b0100;
        @(negedge clk);
        check("bw_m0_wbusy", {31'd0, m0_wbusy}, 0);
        check("bw_ram_wmask", {28'd0, ram_wmask}, 32'h4);
        step();
        m0_wmask = 4'h0;
        rd(0, 14'h0007, 32'h12AB5678);

        // Loader streams writes while the CPU wants one
        m0_addr = 14'h0030; m0_wdata = 32'h55555555; m0_wmask = 4'hF;
        m0_done = 1'b0; m1_cnt = 0; starve = 0; acc = -1;
        for (int cyc = 0; cyc < 20 && (m1_cnt < 8 || !m0_done); cyc++) begin
            if (m1_cnt < 8) begin
                m1_addr = 14'h0020 + 14'(m1_cnt);
                m1_wdata = 32'hA0 + 32'(m1_cnt);
                m1_wmask = 4'hF;
            end else begin
                m1_wmask = 4'h0;
            end
            @(negedge clk);
            if (!m0_done) begin
                if (m0_wbusy) begin
                    if (cyc < 8) starve++;
                end else begin
                    m0_done = 1'b1;
                    acc = cyc;
                end
            end
            if (m1_cnt < 8 && !m1_wbusy) m1_cnt++;
            step();
            if (m0_done) m0_wmask = 4'h0;
        end
        m1_wmask = 4'h0;
        m0_wmask = 4'h0;
        check("stream_m1_count", m1_cnt, 8);
`ifdef ARBITER_ROUND_ROBIN_EN
        check("rr_m0_wbusy_cycles", starve, 1);
        check("rr_m0_accept_cycle", acc, 1);
`else
        check("fp_m0_wbusy_cycles", starve, 8);
        check("fp_m0_accept_cycle", acc, 8);
`endif
        rd(0, 14'h0030, 32'h55555555);
        rd(1, 14'h0027, 32'h000000A7);
        rd(1, 14'h0020, 32'h000000A0);

        repeat (3) step();
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
